reaction_ctrl_n: RTL and testbench
==================================

# reaction_ctrl_n

Parametrised reaction-test controller: successor to the fixed four-digit reaction-test state machine. Adds a configurable digit count and clock rate, an LFSR-randomised start delay, early-press and timeout detection, and a best-time register. It sits between the debounced push-buttons and the seven-segment driver. It outputs packed BCD digits plus a message code the driver renders as letters.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency; the ms prescale is CLK_HZ/1000, which must be an integer ≥ 2.
- `N_DIGITS`, 4, number of BCD digits of millisecond count (1..8).
- `MIN_DELAY_MS`, 2000, fixed part of the random wait.
- `RAND_W`, 11, width of the random wait addend; addend range 0..2^RAND_W-1 ms.
- `LFSR_SEED`, 16'hACE1, LFSR reset value; must be nonzero.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start_i`  in  1  debounced start button, level, synchronous to clk.
- `clear_i`  in  1  debounced clear button, level.
- `stop_i`  in  1  debounced stop button, level.
- `led_o`  out  1  stimulus LED, high only in RUN.
- `digits_o`  out  4*N_DIGITS  current BCD value; digit 0 is in bits [3:0].
- `msg_o`  out  2  display mode: 0 NUM, 1 HI, 2 ERR, 3 SLO.
- `best_o`  out  4*N_DIGITS  best BCD time since the last best clear.
- `new_best_o`  out  1  one-cycle pulse when best_o updates.

## Operation
- Button events use the rising edge only: edge = in & ~in_q, with in_q registered. Held buttons do not retrigger.
- Priority when events coincide: clear > stop > start.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It runs free every cycle from reset, so delays depend on when the user presses start.
- States:
  - IDLE: msg=HI, digits=0, led=0.
    - start → WAIT. On this edge, delay_ms is latched as MIN_DELAY_MS + lfsr[RAND_W-1:0].
    - clear → best_o set to all-9s.
  - WAIT: msg=NUM, digits=0, led=0.
    - The ms counter counts up to delay_ms, then → RUN.
    - stop → EARLY.
    - clear → IDLE.
    - start is ignored.
  - RUN: led=1, msg=NUM.
    - On entry the prescaler and the BCD count are zeroed.
    - The BCD count increments once per ms tick, with a ripple carry across digits.
    - stop → DONE.
    - When the count is all-9s and a tick occurs → TIMEOUT.
    - clear → IDLE.
  - DONE: msg=NUM, digits hold the final count.
    - On entry, if count < best_o, best_o ← count and new_best_o pulses.
    - start → WAIT, as from IDLE.
    - clear → IDLE.
  - EARLY: msg=ERR, digits=0.
    - start → WAIT.
    - clear → IDLE.
  - TIMEOUT: msg=SLO, digits all-9s. Best is not updated.
    - start → WAIT.
    - clear → IDLE.
- Clear returns to IDLE from any non-IDLE state and does not clear best. Clear while in IDLE clears best.
- Comparison is unsigned over the packed BCD vector, which is valid because BCD ordering matches numeric ordering.

## Timing
- Reset values:
  - state=IDLE, led_o=0, digits_o=0, msg_o=HI.
  - best_o all-9s, new_best_o=0.
  - lfsr=LFSR_SEED, in_q=0.
- All outputs are registered.
- Event latency: a rising edge first sampled at clock edge k changes state at edge k; outputs reflect it after edge k.
- ms tick: one cycle high every CLK_HZ/1000 cycles. The prescaler restarts on entry to WAIT and to RUN, so the first tick comes CLK_HZ/1000 cycles after entry.
- WAIT → RUN happens on the tick that makes the elapsed ms equal delay_ms.
- A stop and a tick in the same RUN cycle: stop wins and the tick is not counted. The displayed time is floor(ms).
- new_best_o is high exactly in the first cycle of DONE.
- Reset mid-operation: immediate return to reset values, asynchronously.

## Structure
- Package `reaction_pkg`:
  - `state_t` enum: IDLE, WAIT, RUN, DONE, EARLY, TIMEOUT.
  - `msg_t` enum: NUM, HI, ERR, SLO.
  - LFSR tap constant.
- Sub-module `bcd_counter` (parameter N_DIGITS), used for the RUN count:
  - Ports: clk, rst_n, clr_i, inc_i, bcd_o, max_o (all-9s).
  - Saturating: inc at max holds the value.
- WAIT uses a plain binary ms counter of width RAND_W+ceil(log2(MIN_DELAY_MS))+1.

## Test plan
Benches use CLK_HZ=10_000 (10 cycles/ms), N_DIGITS=2, MIN_DELAY_MS=5, RAND_W=2.
- Reset, no input → msg=HI, led=0, best=8'h99, digits=0.
- start; record delay_ms (5..8); stop 37 ms after led rises → led high exactly delay_ms*10 cycles after the start edge; DONE with digits=8'h37; new_best pulse; best=8'h37.
- Second round with stop at 50 ms → digits=8'h50, no new_best, best stays 8'h37.
- stop during WAIT → msg=ERR, led never rises.
- RUN with no stop → digits saturate at 8'h99, then TIMEOUT with msg=SLO; best unchanged.
- Simultaneous clear+stop in RUN → IDLE. Then clear in IDLE → best=8'h99. Holding start through DONE does not restart until it is released and pressed again. rst_n asserted mid-RUN → reset values on the next cycle.

Source files
------------

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and constants for the reaction-test controller.
// Provides the controller state and display message encodings, the LFSR tap mask
// and a helper that maps a state to the message code shown by the display driver.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    EARLY   = 3'd4,
    TIMEOUT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    NUM = 2'd0,
    HI  = 2'd1,
    ERR = 2'd2,
    SLO = 2'd3
  } msg_t;

  // Right-shifting Fibonacci LFSR: taps 16,14,13,11 counted from the output end
  // are bits 0,2,3,5 of the register.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic msg_t state_msg(input state_t s);
    case (s)
      IDLE:    return HI;
      EARLY:   return ERR;
      TIMEOUT: return SLO;
      default: return NUM;
    endcase
  endfunction

endpackage

// File: rtl/reaction_ctrl_n_bcd.sv
// bcd_counter: N_DIGITS-digit saturating BCD counter with ripple carry.
// Ports: clk, rst_n (async active-low), clr_i (zero, wins over inc_i),
//        inc_i (add one unless at all-9s), bcd_o (packed digits, digit 0 in [3:0]), max_o.
module bcd_counter #(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  inc_i,
  output logic [4*N_DIGITS-1:0] bcd_o,
  output logic                  max_o
);

  localparam logic [4*N_DIGITS-1:0] ALL9 = {N_DIGITS{4'h9}};

  logic [4*N_DIGITS-1:0] cnt_q, cnt_d;
  logic                  carry;

  assign max_o = (cnt_q == ALL9);
  assign bcd_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    carry = inc_i && !max_o;
    if (clr_i) begin
      cnt_d = '0;
      carry = 1'b0;
    end
    // Each digit that is already 9 wraps to 0 and passes the carry upward.
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] == 4'd9) begin
          cnt_d[4*i +: 4] = 4'd0;
        end else begin
          cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reaction_ctrl_n.sv
// reaction_ctrl_n: reaction-test controller with random start delay, early/timeout detection
// and best-time register. Inputs: start_i/clear_i/stop_i debounced levels (rising edge acts).
// Outputs (all registered): led_o, digits_o (BCD), msg_o (0 NUM,1 HI,2 ERR,3 SLO), best_o, new_best_o.
module reaction_ctrl_n
  import reaction_pkg::*;
#(
  parameter int          CLK_HZ       = 100_000_000,
  parameter int          N_DIGITS     = 4,
  parameter int          MIN_DELAY_MS = 2000,
  parameter int          RAND_W       = 11,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic                  stop_i,
  output logic                  led_o,
  output logic [4*N_DIGITS-1:0] digits_o,
  output logic [1:0]            msg_o,
  output logic [4*N_DIGITS-1:0] best_o,
  output logic                  new_best_o
);

  localparam int PRESC = CLK_HZ / 1000;
  localparam int PW    = $clog2(PRESC);
  localparam int MSW   = RAND_W + $clog2(MIN_DELAY_MS) + 1;
  localparam logic [4*N_DIGITS-1:0] ALL9 = {N_DIGITS{4'h9}};

  state_t                state_q, state_d;
  logic                  start_q, clear_q, stop_q;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [MSW-1:0]        ms_q, ms_d, delay_q, delay_d, ms_inc;
  logic [4*N_DIGITS-1:0] best_q, best_d, cnt;
  logic                  new_best_q, new_best_d, led_q, led_d;
  msg_t                  msg_q, msg_d;
  logic                  start_ev, clear_ev, stop_ev, tick, entering;
  logic                  cnt_clr, cnt_inc, cnt_max;

  assign start_ev = start_i & ~start_q;
  assign clear_ev = clear_i & ~clear_q;
  assign stop_ev  = stop_i  & ~stop_q;
  assign tick     = (presc_q == PW'(PRESC - 1));
  assign ms_inc   = ms_q + MSW'(1);

  bcd_counter #(.N_DIGITS(N_DIGITS)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .bcd_o (cnt),
    .max_o (cnt_max)
  );

  // Event priority everywhere: clear > stop > start/tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!clear_ev && start_ev) state_d = WAIT;
      WAIT: begin
        if (clear_ev)                     state_d = IDLE;
        else if (stop_ev)                 state_d = EARLY;
        else if (tick && ms_inc == delay_q) state_d = RUN;
      end
      RUN: begin
        if (clear_ev)            state_d = IDLE;
        else if (stop_ev)        state_d = DONE;
        else if (tick && cnt_max) state_d = TIMEOUT;
      end
      DONE, EARLY, TIMEOUT: begin
        if (clear_ev)      state_d = IDLE;
        else if (start_ev) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // The BCD counter register doubles as the digit display: it is zeroed on entry to
  // every state that shows 0, holds in DONE, and is already saturated at all-9s in TIMEOUT.
  always_comb begin
    entering   = (state_d != state_q);
    lfsr_d     = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    presc_d    = ((entering && (state_d == WAIT || state_d == RUN)) || tick) ? '0 : presc_q + PW'(1);
    ms_d       = ms_q;
    delay_d    = delay_q;
    if (entering && state_d == WAIT) begin
      ms_d    = '0;
      delay_d = MSW'(MIN_DELAY_MS) + MSW'(lfsr_q[RAND_W-1:0]);
    end else if (state_q == WAIT && tick) begin
      ms_d = ms_inc;
    end
    cnt_clr    = entering && (state_d == IDLE || state_d == WAIT || state_d == EARLY || state_d == RUN);
    cnt_inc    = (state_q == RUN) && (state_d == RUN) && tick;
    best_d     = best_q;
    new_best_d = 1'b0;
    if (state_q == IDLE && clear_ev) begin
      best_d = ALL9;
    end else if (state_q == RUN && state_d == DONE && cnt < best_q) begin
      // Stop suppresses the tick, so cnt is already the final time.
      best_d     = cnt;
      new_best_d = 1'b1;
    end
    led_d      = (state_d == RUN);
    msg_d      = state_msg(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      clear_q    <= 1'b0;
      stop_q     <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      presc_q    <= '0;
      ms_q       <= '0;
      delay_q    <= '0;
      best_q     <= ALL9;
      new_best_q <= 1'b0;
      led_q      <= 1'b0;
      msg_q      <= HI;
    end else begin
      state_q    <= state_d;
      start_q    <= start_i;
      clear_q    <= clear_i;
      stop_q     <= stop_i;
      lfsr_q     <= lfsr_d;
      presc_q    <= presc_d;
      ms_q       <= ms_d;
      delay_q    <= delay_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
      led_q      <= led_d;
      msg_q      <= msg_d;
    end
  end

  assign led_o      = led_q;
  assign digits_o   = cnt;
  assign msg_o      = msg_q;
  assign best_o     = best_q;
  assign new_best_o = new_best_q;

endmodule

// File: tb/tb_reaction_ctrl_n.sv
module tb_reaction_ctrl_n;

  localparam logic [1:0] M_NUM = 2'd0, M_HI = 2'd1, M_ERR = 2'd2, M_SLO = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0, clear_i = 1'b0, stop_i = 1'b0;
  logic       led_o, new_best_o;
  logic [7:0] digits_o, best_o;
  logic [1:0] msg_o;

  int checks = 0;
  int errors = 0;

  reaction_ctrl_n #(
    .CLK_HZ(10_000), .N_DIGITS(2), .MIN_DELAY_MS(5), .RAND_W(2), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i), .stop_i(stop_i),
    .led_o(led_o), .digits_o(digits_o), .msg_o(msg_o), .best_o(best_o), .new_best_o(new_best_o)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting right.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] msg, input logic led,
                           input logic [7:0] dig, input logic [7:0] best);
    check({tag, ".msg"},    msg_o,    msg);
    check({tag, ".led"},    led_o,    led);
    check({tag, ".digits"}, digits_o, dig);
    check({tag, ".best"},   best_o,   best);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic st, input logic cl, input logic sp);
    @(negedge clk);
    start_i = st; clear_i = cl; stop_i = sp;
    @(negedge clk);
    start_i = 1'b0; clear_i = 1'b0; stop_i = 1'b0;
  endtask

  // Press start, then count cycles from the start edge until led_o rises.
  // Returns at the negedge right after the edge on which led_o went high.
  task automatic start_and_wait_led(input string tag, input bit hold);
    int exp_d;
    int cyc;
    @(negedge clk);
    start_i = 1'b1;
    exp_d = 5 + int'(m_lfsr[1:0]);
    @(negedge clk);
    if (!hold) start_i = 1'b0;
    cyc = 0;
    while (!led_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".led_delay"}, cyc, exp_d * 10);
  endtask

  typedef struct {
    logic       st, cl, sp;
    int         waitc;
    logic [1:0] msg;
    logic       led;
    logic [7:0] dig;
    logic [7:0] best;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl = '{
      '{1'b0, 1'b0, 1'b0, 0,   M_HI,  1'b0, 8'h00, 8'h99},  // idle, no input
      '{1'b0, 1'b1, 1'b0, 0,   M_HI,  1'b0, 8'h00, 8'h99},  // clear in idle
      '{1'b1, 1'b0, 1'b0, 0,   M_NUM, 1'b0, 8'h00, 8'h99},  // start -> wait
      '{1'b1, 1'b0, 1'b0, 0,   M_NUM, 1'b0, 8'h00, 8'h99},  // start ignored in wait
      '{1'b0, 1'b0, 1'b1, 100, M_ERR, 1'b0, 8'h00, 8'h99},  // early stop, led never rises
      '{1'b1, 1'b0, 1'b0, 0,   M_NUM, 1'b0, 8'h00, 8'h99},  // early -> wait
      '{1'b0, 1'b1, 1'b0, 0,   M_HI,  1'b0, 8'h00, 8'h99},  // wait -> idle
      '{1'b1, 1'b1, 1'b0, 0,   M_HI,  1'b0, 8'h00, 8'h99},  // clear beats start
      '{1'b1, 1'b0, 1'b0, 0,   M_NUM, 1'b0, 8'h00, 8'h99},
      '{1'b0, 1'b1, 1'b1, 0,   M_HI,  1'b0, 8'h00, 8'h99},  // clear beats stop in wait
      '{1'b1, 1'b0, 1'b0, 0,   M_NUM, 1'b0, 8'h00, 8'h99},
      '{1'b0, 1'b0, 1'b1, 0,   M_ERR, 1'b0, 8'h00, 8'h99},
      '{1'b1, 1'b1, 1'b0, 0,   M_HI,  1'b0, 8'h00, 8'h99}   // clear beats start in early
    };

    // Reset values
    wait_neg(3);
    check_out("reset", M_HI, 1'b0, 8'h00, 8'h99);
    check("reset.new_best", new_best_o, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      press(tbl[i].st, tbl[i].cl, tbl[i].sp);
      wait_neg(tbl[i].waitc);
      check_out($sformatf("vec%0d", i), tbl[i].msg, tbl[i].led, tbl[i].dig, tbl[i].best);
    end

    // Round 1: stop at 37 ms -> new best
    start_and_wait_led("r1", 1'b0);
    wait_neg(205);
    check("r1.mid_digits", digits_o, 8'h20);
    wait_neg(169);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check_out("r1.done", M_NUM, 1'b0, 8'h37, 8'h37);
    check("r1.new_best", new_best_o, 1'b1);
    @(negedge clk);
    check("r1.new_best_pulse", new_best_o, 1'b0);
    check("r1.hold_digits", digits_o, 8'h37);

    // Round 2: stop at 50 ms -> no new best
    start_and_wait_led("r2", 1'b0);
    wait_neg(504);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check_out("r2.done", M_NUM, 1'b0, 8'h50, 8'h37);
    check("r2.new_best", new_best_o, 1'b0);

    // Round 3: start held through the whole run; DONE must not restart
    start_and_wait_led("r3", 1'b1);
    wait_neg(604);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check_out("r3.done", M_NUM, 1'b0, 8'h60, 8'h37);
    wait_neg(20);
    check_out("r3.held", M_NUM, 1'b0, 8'h60, 8'h37);
    start_i = 1'b0;

    // Round 4: no stop -> saturate at 99 then TIMEOUT
    start_and_wait_led("r4", 1'b0);
    wait_neg(995);
    check_out("r4.sat", M_NUM, 1'b1, 8'h99, 8'h37);
    wait_neg(4);
    check_out("r4.last_run", M_NUM, 1'b1, 8'h99, 8'h37);
    wait_neg(1);
    check_out("r4.timeout", M_SLO, 1'b0, 8'h99, 8'h37);
    check("r4.new_best", new_best_o, 1'b0);

    // Round 5: clear+stop together in RUN -> IDLE, best kept; then clear in IDLE
    start_and_wait_led("r5", 1'b0);
    wait_neg(30);
    press(1'b0, 1'b1, 1'b1);
    check_out("r5.clear_run", M_HI, 1'b0, 8'h00, 8'h37);
    press(1'b0, 1'b1, 1'b0);
    check_out("r5.clear_idle", M_HI, 1'b0, 8'h00, 8'h99);

    // Round 6: stop at 3 ms -> best 03
    start_and_wait_led("r6", 1'b0);
    wait_neg(34);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check_out("r6.done", M_NUM, 1'b0, 8'h03, 8'h03);
    check("r6.new_best", new_best_o, 1'b1);

    // Round 7: asynchronous reset mid-RUN
    start_and_wait_led("r7", 1'b0);
    wait_neg(50);
    check("r7.running", led_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check_out("r7.reset", M_HI, 1'b0, 8'h00, 8'h99);
    check("r7.reset.new_best", new_best_o, 1'b0);
    @(negedge clk);
    check_out("r7.reset_hold", M_HI, 1'b0, 8'h00, 8'h99);
    rst_n = 1'b1;
    wait_neg(2);
    check_out("r7.after", M_HI, 1'b0, 8'h00, 8'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
